avalon_pio_out_pulse: RTL and testbench

//  Parametrised Avalon-MM output PIO for the NIOS2 system (GPIO, UART-TX control lines).

---
 rtl/avalon_pio_out_pulse_if.sv | 26 ++
 rtl/avalon_pio_out_pulse.sv | 192 +++++++++++++++++++
 tb/tb_avalon_pio_out_pulse.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_pio_out_pulse_if.sv
// Avalon-MM slave bus bundle for the output PIO: address/strobes/write data in, read data out.
interface avalon_pio_out_pulse_if #(
  parameter int DATA_WIDTH = 32
);
  logic [2:0]            address;
  logic                  chipselect;
  logic                  write_n;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/avalon_pio_out_pulse.sv
// Avalon-MM output PIO with atomic set/clear and a hardware one-shot pulse engine.
// Define PIO_PULSE_IRQ_EN to add the pulse-done interrupt (o_irq) and STATUS bit1.
module avalon_pio_out_pulse #(
  parameter int                    DATA_WIDTH    = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = '0,
  parameter int                    CNT_WIDTH     = 16,
  parameter int                    DEF_PULSE_LEN = 100
) (
  input  logic                  clk,
  input  logic                  reset_n,
  avalon_pio_out_pulse_if.slave bus,
  output logic [DATA_WIDTH-1:0] o_out_port
`ifdef PIO_PULSE_IRQ_EN
  ,
  output logic                  o_irq
`endif
);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_PULSE  = 3'd2;
  localparam logic [2:0] A_LEN    = 3'd3;
  localparam logic [2:0] A_SET    = 3'd4;
  localparam logic [2:0] A_CLEAR  = 3'd5;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic [DATA_WIDTH-1:0] r_mask;
  logic [DATA_WIDTH-1:0] w_mask_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;
  logic [CNT_WIDTH-1:0]  r_len;
  logic [CNT_WIDTH-1:0]  w_len_nxt;

  logic [DATA_WIDTH-1:0] w_wd;
  logic [CNT_WIDTH-1:0]  w_len_wr;
  logic [CNT_WIDTH-1:0]  w_len_eff;
  logic                  w_wr;
  logic                  w_wr_data;
  logic                  w_wr_status;
  logic                  w_wr_pulse;
  logic                  w_wr_len;
  logic                  w_wr_set;
  logic                  w_wr_clear;
  logic                  w_expire;
  logic                  w_busy;
  logic                  w_irq_bit;
  logic [31:0]           w_rd_ext;

  assign w_wd        = bus.writedata;
  assign w_wr        = bus.chipselect & ~bus.write_n;
  assign w_wr_data   = w_wr && (bus.address == A_DATA);
  assign w_wr_status = w_wr && (bus.address == A_STATUS);
  assign w_wr_pulse  = w_wr && (bus.address == A_PULSE) && (w_wd != '0);
  assign w_wr_len    = w_wr && (bus.address == A_LEN);
  assign w_wr_set    = w_wr && (bus.address == A_SET);
  assign w_wr_clear  = w_wr && (bus.address == A_CLEAR);

  // PULSE_LEN is zero-extended or truncated to the counter width on write.
  assign w_len_wr  = CNT_WIDTH'(w_wd);
  assign w_len_eff = (r_len == '0) ? CNT_WIDTH'(1) : r_len;
  assign w_busy    = (r_state == S_ACTIVE);

  // A DATA write or a non-empty PULSE write pre-empts the expiry in the same cycle.
  assign w_expire = w_busy && (r_cnt == CNT_WIDTH'(1)) && !w_wr_data && !w_wr_pulse;

  // Expiry is applied first, then set/clear; this gives "set wins" for OUTSET
  // and "clear then expire remaining MASK" for OUTCLEAR in one ordering.
  always_comb begin : next_state
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_mask_nxt  = r_mask;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;

    if (r_state == S_ACTIVE) begin
      w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
    end

    if (w_expire) begin
      w_data_nxt  = r_data & ~r_mask;
      w_mask_nxt  = '0;
      w_cnt_nxt   = '0;
      w_state_nxt = S_IDLE;
    end

    if (w_wr_set) begin
      w_data_nxt = w_data_nxt | w_wd;
    end

    if (w_wr_clear) begin
      w_data_nxt = w_data_nxt & ~w_wd;
      w_mask_nxt = w_mask_nxt & ~w_wd;
      if (w_mask_nxt == '0) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    end

    if (w_wr_len) begin
      w_len_nxt = w_len_wr;
    end

    if (w_wr_pulse) begin
      w_data_nxt  = r_data | w_wd;
      w_mask_nxt  = r_mask | w_wd;
      w_cnt_nxt   = w_len_eff;
      w_state_nxt = S_ACTIVE;
    end

    if (w_wr_data) begin
      w_data_nxt  = w_wd;
      w_mask_nxt  = '0;
      w_cnt_nxt   = '0;
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_data  <= RESET_VALUE;
      r_mask  <= '0;
      r_cnt   <= '0;
      r_len   <= CNT_WIDTH'(DEF_PULSE_LEN);
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_mask  <= w_mask_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
    end
  end

`ifdef PIO_PULSE_IRQ_EN
  localparam int CLR_BIT = (DATA_WIDTH > 1) ? 1 : 0;

  logic r_irq_pend;
  logic w_irq_pend_nxt;
  logic w_irq_set;
  logic w_irq_clr;

  // An OUTCLEAR that empties MASK on the expiry cycle cancels the pulse, so no interrupt.
  assign w_irq_set = w_expire && (!w_wr_clear || ((r_mask & ~w_wd) != '0));
  assign w_irq_clr = w_wr_status && (DATA_WIDTH > 1) && w_wd[CLR_BIT];

  always_comb begin : irq_next
    w_irq_pend_nxt = r_irq_pend;
    if (w_irq_clr) begin
      w_irq_pend_nxt = 1'b0;
    end
    if (w_irq_set) begin
      w_irq_pend_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_pend <= 1'b0;
    end else begin
      r_irq_pend <= w_irq_pend_nxt;
    end
  end

  assign w_irq_bit = r_irq_pend;
  assign o_irq     = r_irq_pend;
`else
  assign w_irq_bit = 1'b0;
`endif

  always_comb begin : read_mux
    w_rd_ext = '0;
    case (bus.address)
      A_DATA:   w_rd_ext = 32'(r_data);
      A_STATUS: w_rd_ext = {30'd0, w_irq_bit, w_busy};
      A_PULSE:  w_rd_ext = 32'(r_mask);
      A_LEN:    w_rd_ext = 32'(r_len);
      default:  w_rd_ext = '0;
    endcase
  end

  assign bus.readdata = w_rd_ext[DATA_WIDTH-1:0];
  assign o_out_port   = r_data;

endmodule

// File: tb/tb_avalon_pio_out_pulse.sv
// Bench for avalon_pio_out_pulse: directed table, hand-written pulse sequences and
// randomized bus traffic against a deadline-based reference model.
module tb_avalon_pio_out_pulse;

  localparam int          DW = 32;
  localparam logic [31:0] RV = 32'hA5;
`ifdef PIO_PULSE_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] out_port;
`ifdef PIO_PULSE_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  avalon_pio_out_pulse_if #(.DATA_WIDTH(DW)) bus_if ();

  avalon_pio_out_pulse #(
    .DATA_WIDTH   (DW),
    .RESET_VALUE  (RV),
    .CNT_WIDTH    (16),
    .DEF_PULSE_LEN(100)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus_if.slave),
    .o_out_port(out_port)
`ifdef PIO_PULSE_IRQ_EN
    ,
    .o_irq     (irq)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pulse bits expire at an absolute edge number (deadline).
  logic [31:0] m_data;
  logic [31:0] m_mask;
  logic [15:0] m_len;
  bit          m_pend;
  int          m_end;
  int          edge_no = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_data = RV;
    m_mask = '0;
    m_len  = 16'd100;
    m_pend = 1'b0;
    m_end  = -1;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return m_data;
      3'd1:    return {30'd0, (IRQ_EN ? m_pend : 1'b0), (m_mask != 0)};
      3'd2:    return m_mask;
      3'd3:    return {16'd0, m_len};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge(input bit wr, input logic [2:0] a, input logic [31:0] wd);
    int          e;
    bit          blocked;
    bit          expire;
    bit          set_p;
    bit          clr_p;
    logic [31:0] old_mask;
    e        = edge_no;
    edge_no  = edge_no + 1;
    blocked  = wr && (a == 3'd0 || (a == 3'd2 && wd != 0));
    expire   = (m_mask != 0) && (e == m_end) && !blocked;
    set_p    = 1'b0;
    clr_p    = 1'b0;
    old_mask = m_mask;
    if (expire) begin
      set_p  = !(wr && a == 3'd5 && (old_mask & ~wd) == 0);
      m_data = m_data & ~old_mask;
      m_mask = '0;
    end
    if (wr) begin
      case (a)
        3'd0: begin m_data = wd; m_mask = '0; end
        3'd1: clr_p = wd[1];
        3'd2: if (wd != 0) begin
                m_data = m_data | wd;
                m_mask = m_mask | wd;
                m_end  = e + ((m_len == 0) ? 1 : int'(m_len));
              end
        3'd3: m_len = wd[15:0];
        3'd4: m_data = m_data | wd;
        3'd5: begin m_data = m_data & ~wd; m_mask = m_mask & ~wd; end
        default: ;
      endcase
    end
    if (set_p) m_pend = 1'b1;
    else if (clr_p) m_pend = 1'b0;
  endtask

  // One bus cycle, entered just after a falling edge: readdata sampled before the
  // rising edge, out_port sampled at the following falling edge.
  task automatic step(input bit wr, input logic [2:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic [31:0] outp);
    if (wr) begin
      bus_if.chipselect = 1'b1;
      bus_if.write_n    = 1'b0;
    end else begin
      case ($urandom_range(0, 2))
        0:       begin bus_if.chipselect = 1'b1; bus_if.write_n = 1'b1; end
        1:       begin bus_if.chipselect = 1'b0; bus_if.write_n = 1'b0; end
        default: begin bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1; end
      endcase
    end
    bus_if.address   = a;
    bus_if.writedata = wd;
    #1;
    rd = bus_if.readdata;
    @(posedge clk);
    model_edge(wr, a, wd);
    @(negedge clk);
    outp = out_port;
  endtask

  typedef struct {
    bit          wr;
    logic [2:0]  a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [31:0] exp_out;
  } vec_t;

  vec_t        tbl[12];
  logic [31:0] rd;
  logic [31:0] o;
  int          cnt_a;
  int          cnt_b;
  int          cnt_c;

  initial begin
    tbl[0]  = '{1'b0, 3'd3, 32'h0,        32'd100,  32'hA5};
    tbl[1]  = '{1'b0, 3'd1, 32'h0,        32'h0,    32'hA5};
    tbl[2]  = '{1'b0, 3'd0, 32'h0,        32'hA5,   32'hA5};
    tbl[3]  = '{1'b1, 3'd0, 32'h0F,       32'hA5,   32'h0F};
    tbl[4]  = '{1'b1, 3'd4, 32'hF0,       32'h0,    32'hFF};
    tbl[5]  = '{1'b1, 3'd5, 32'h03,       32'h0,    32'hFC};
    tbl[6]  = '{1'b0, 3'd0, 32'h0,        32'hFC,   32'hFC};
    tbl[7]  = '{1'b0, 3'd6, 32'h0,        32'h0,    32'hFC};
    tbl[8]  = '{1'b1, 3'd6, 32'hFFFFFFFF, 32'h0,    32'hFC};
    tbl[9]  = '{1'b0, 3'd2, 32'h0,        32'h0,    32'hFC};
    tbl[10] = '{1'b1, 3'd3, 32'h5,        32'd100,  32'hFC};
    tbl[11] = '{1'b0, 3'd3, 32'h0,        32'h5,    32'hFC};

    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.address    = 3'd0;
    bus_if.writedata  = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_out", out_port, RV);
`ifdef PIO_PULSE_IRQ_EN
    check("reset_irq", {31'd0, irq}, 32'd0);
`endif
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].wr, tbl[i].a, tbl[i].wd, rd, o);
      check($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
      check($sformatf("tbl%0d_out", i), o, tbl[i].exp_out);
    end

    // PULSE_LEN=5: bit0 high exactly 5 cycles, busy seen for 5 cycles.
    step(1'b1, 3'd0, 32'h0, rd, o);
    step(1'b1, 3'd2, 32'h1, rd, o);
    cnt_a = int'(o[0]);
    cnt_b = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 3'd1, 32'h0, rd, o);
      cnt_a += int'(o[0]);
      cnt_b += int'(rd[0]);
    end
    check("pulse5_high", cnt_a, 32'd5);
    check("pulse5_busy", cnt_b, 32'd5);
    check("pulse5_pend", {31'd0, rd[1]}, {31'd0, IRQ_EN});
`ifdef PIO_PULSE_IRQ_EN
    check("pulse5_irq", {31'd0, irq}, 32'd1);
`endif
    step(1'b1, 3'd1, 32'h2, rd, o);
`ifdef PIO_PULSE_IRQ_EN
    check("irq_clear", {31'd0, irq}, 32'd0);
`endif

    // PULSE_LEN=0 gives one cycle; then retrigger with a second bit at cycle 6.
    step(1'b1, 3'd3, 32'h0, rd, o);
    step(1'b1, 3'd2, 32'h2, rd, o);
    cnt_a = int'(o[1]);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 3'd0, 32'h0, rd, o);
      cnt_a += int'(o[1]);
    end
    check("pulse0_high", cnt_a, 32'd1);
    step(1'b1, 3'd3, 32'h8, rd, o);
    step(1'b1, 3'd2, 32'h4, rd, o);
    cnt_a = int'(o[2]);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 3'd2, 32'h0, rd, o);
      cnt_a += int'(o[2]);
    end
    step(1'b1, 3'd2, 32'h8, rd, o);
    cnt_a += int'(o[2]);
    cnt_b = int'(o[3:2] == 2'b11);
    cnt_c = int'(o[3] != o[2]);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 3'd1, 32'h0, rd, o);
      cnt_a += int'(o[2]);
      cnt_b += int'(o[3:2] == 2'b11);
      cnt_c += int'(o[3] != o[2]);
    end
    check("retrig_bit2", cnt_a, 32'd14);
    check("retrig_both", cnt_b, 32'd8);
    check("retrig_split", cnt_c, 32'd0);
    step(1'b1, 3'd1, 32'h2, rd, o);

    // DATA write mid-pulse aborts: no output, not busy, no interrupt afterwards.
    step(1'b1, 3'd3, 32'd10, rd, o);
    step(1'b1, 3'd2, 32'h10, rd, o);
    step(1'b0, 3'd0, 32'h0, rd, o);
    step(1'b0, 3'd0, 32'h0, rd, o);
    step(1'b1, 3'd0, 32'h0, rd, o);
    cnt_a = 0;
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 3'd1, 32'h0, rd, o);
      cnt_a += int'(o != 0) + int'(rd[1:0] != 2'b00);
`ifdef PIO_PULSE_IRQ_EN
      cnt_a += int'(irq);
`endif
    end
    check("abort_quiet", cnt_a, 32'd0);

    // Randomized traffic with short pulse lengths to provoke same-cycle collisions.
    for (int i = 0; i < 600; i++) begin
      bit          wr;
      logic [2:0]  a;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      wr = ($urandom_range(0, 2) != 0);
      a  = 3'($urandom_range(0, 7));
      wd = $urandom;
      if ($urandom_range(0, 1) == 1) wd = wd & 32'hFF;
      if (a == 3'd3) wd = $urandom_range(0, 6);
      if (a == 3'd2) wd = ($urandom_range(0, 7) == 0) ? 32'h0 : (wd & 32'h0F0F);
      if (a == 3'd0 && $urandom_range(0, 3) != 0) wr = 1'b0;
      exp_rd = model_read(a);
      step(wr, a, wd, rd, o);
      check($sformatf("rnd%0d_rd", i), rd, exp_rd);
      check($sformatf("rnd%0d_out", i), o, m_data);
`ifdef PIO_PULSE_IRQ_EN
      check($sformatf("rnd%0d_irq", i), {31'd0, irq}, {31'd0, m_pend});
`endif
    end

    // Asynchronous reset in the middle of a pulse.
    step(1'b1, 3'd3, 32'd20, rd, o);
    step(1'b1, 3'd2, 32'h100, rd, o);
    for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 32'h0, rd, o);
    check("pre_reset_out", o, m_data);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_out", out_port, RV);
`ifdef PIO_PULSE_IRQ_EN
    check("async_reset_irq", {31'd0, irq}, 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    step(1'b0, 3'd3, 32'h0, rd, o);
    check("post_reset_len", rd, 32'd100);
    check("post_reset_out", o, RV);
    step(1'b0, 3'd1, 32'h0, rd, o);
    check("post_reset_status", rd, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
